line_buf_ctrl: RTL and testbench

LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

---
 rtl/coproc_pkg.sv | 14 +
 rtl/row_buf_bank.sv | 41 ++++
 rtl/line_buf_ctrl.sv | 122 ++++++++++++
 tb/tb_line_buf_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// coproc_pkg: shared state encoding, default geometry and row-pointer helpers
package coproc_pkg;
    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FILL, S_SCAN, S_FLUSH, S_FINISH} state_e;
    localparam int IMG_W_DEF = 256;
    localparam int IMG_H_DEF = 256;
    localparam int PIX_W_DEF = 12;
    localparam logic [2:0] ONEHOT_INIT = 3'b001;
    function automatic logic [2:0] rot_onehot(input logic [2:0] v);
        return {v[1:0], v[2]};
    endfunction
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/row_buf_bank.sv
// row_buf_bank: three row buffers with per-column write, single-row clear and bulk clear
module row_buf_bank
    import coproc_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int PIX_W = PIX_W_DEF,
    localparam int CW = $clog2(IMG_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_all,
    input  logic                   clr_one,
    input  logic [1:0]             clr_sel,
    input  logic                   we,
    input  logic [1:0]             wr_sel,
    input  logic [CW-1:0]          wr_col,
    input  logic [PIX_W-1:0]       wdata,
    output logic [IMG_W*PIX_W-1:0] rdata0,
    output logic [IMG_W*PIX_W-1:0] rdata1,
    output logic [IMG_W*PIX_W-1:0] rdata2
);
    logic [2:0][IMG_W*PIX_W-1:0] buf_q, buf_d;
    always_comb begin
        buf_d = buf_q;
        if (clr_all)
            buf_d = '0;
        else if (clr_one)
            buf_d[clr_sel] = '0;
        else if (we)
            buf_d[wr_sel][PIX_W*int'(wr_col) +: PIX_W] = wdata;
    end
    always_ff @(posedge clk) begin
        if (rst)
            buf_q <= '0;
        else
            buf_q <= buf_d;
    end
    assign rdata0 = buf_q[0];
    assign rdata1 = buf_q[1];
    assign rdata2 = buf_q[2];
endmodule

// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: frame FSM streaming raster pixels into three row buffers and presenting 3-row windows
module line_buf_ctrl
    import coproc_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int PIX_W = PIX_W_DEF,
    localparam int CW = $clog2(IMG_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PIX_W-1:0]       pix_in,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    output logic [IMG_W*PIX_W-1:0] rdata0_in,
    output logic [IMG_W*PIX_W-1:0] rdata1_in,
    output logic [IMG_W*PIX_W-1:0] rdata2_in,
    output logic [CW-1:0]          col_cnt,
    output logic [2:0]             row_sel_onehot,
    output logic                   win_valid,
    input  logic                   win_ready,
    output logic                   busy,
    output logic                   done
);
    state_e        state_q, state_d;
    logic [1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] wr_col_q, wr_col_d, col_cnt_q, col_cnt_d;
    logic [2:0]    row_sel_q, row_sel_d;
    logic [8:0]    fill_cnt_q, fill_cnt_d, out_row_q, out_row_d;
    logic          clr_all, clr_one, acc, hs;
    assign pix_ready      = state_q == S_FILL;
    assign win_valid      = state_q == S_SCAN;
    assign busy           = state_q != S_IDLE;
    assign done           = state_q == S_FINISH;
    assign col_cnt        = col_cnt_q;
    assign row_sel_onehot = row_sel_q;
    assign acc            = pix_ready && pix_valid;
    assign hs             = win_valid && win_ready;
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_col_d   = wr_col_q;
        col_cnt_d  = col_cnt_q;
        row_sel_d  = row_sel_q;
        fill_cnt_d = fill_cnt_q;
        out_row_d  = out_row_q;
        clr_all    = 1'b0;
        clr_one    = 1'b0;
        case (state_q)
            S_IDLE: state_d = start ? S_CLEAR : S_IDLE;
            S_CLEAR: begin
                clr_all    = 1'b1;
                wr_ptr_d   = 2'd1;
                wr_col_d   = '0;
                col_cnt_d  = '0;
                row_sel_d  = ONEHOT_INIT;
                fill_cnt_d = '0;
                out_row_d  = '0;
                state_d    = S_FILL;
            end
            S_FILL: if (acc) begin
                wr_col_d = wr_col_q + 1'b1;
                if (wr_col_q == CW'(IMG_W - 1)) begin
                    wr_ptr_d   = ptr_inc(wr_ptr_q);
                    fill_cnt_d = fill_cnt_q + 9'd1;
                    // first fill needs two rows before any window exists
                    state_d    = (fill_cnt_q != '0) ? S_SCAN : S_FILL;
                end
            end
            S_SCAN: if (hs) begin
                col_cnt_d = col_cnt_q + 1'b1;
                if (col_cnt_q == CW'(IMG_W - 1)) begin
                    row_sel_d = rot_onehot(row_sel_q);
                    out_row_d = out_row_q + 9'd1;
                    state_d   = (out_row_q + 9'd2 <= 9'(IMG_H - 1)) ? S_FILL :
                                (out_row_q + 9'd1 <= 9'(IMG_H - 1)) ? S_FLUSH : S_FINISH;
                end
            end
            S_FLUSH: begin
                clr_one  = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
                state_d  = S_SCAN;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            wr_col_q   <= '0;
            col_cnt_q  <= '0;
            row_sel_q  <= ONEHOT_INIT;
            fill_cnt_q <= '0;
            out_row_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_col_q   <= wr_col_d;
            col_cnt_q  <= col_cnt_d;
            row_sel_q  <= row_sel_d;
            fill_cnt_q <= fill_cnt_d;
            out_row_q  <= out_row_d;
        end
    end
    row_buf_bank #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clr_all (clr_all),
        .clr_one (clr_one),
        .clr_sel (wr_ptr_q),
        .we      (acc),
        .wr_sel  (wr_ptr_q),
        .wr_col  (wr_col_q),
        .wdata   (pix_in),
        .rdata0  (rdata0_in),
        .rdata1  (rdata1_in),
        .rdata2  (rdata2_in)
    );
endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: directed checks of a 4x3 frame, stall, ignored inputs and mid-frame reset
module tb_line_buf_ctrl;
    localparam int W = 4, H = 3, P = 12;
    logic clk = 0, rst = 1, start = 0, pix_valid = 0, win_ready = 0;
    logic [P-1:0] pix_in = '0;
    logic pix_ready, win_valid, busy, done;
    logic [W*P-1:0] r0, r1, r2;
    logic [1:0] col_cnt;
    logic [2:0] row_sel;
    int n_tests = 0, n_fail = 0, hs_cnt = 0, done_cnt = 0;
    always #5 clk = ~clk;
    line_buf_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .rdata0_in(r0), .rdata1_in(r1), .rdata2_in(r2),
        .col_cnt(col_cnt), .row_sel_onehot(row_sel), .win_valid(win_valid),
        .win_ready(win_ready), .busy(busy), .done(done)
    );
    always @(posedge clk) begin
        if (win_valid && win_ready) hs_cnt++;
        if (done) done_cnt++;
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [W*P-1:0] pk(input int a);
        logic [W*P-1:0] r;
        for (int c = 0; c < W; c++) r[P*c +: P] = P'(a + c);
        return r;
    endfunction
    task automatic do_start();
        start = 1;
        tick();
        start = 0;
        tick();
    endtask
    task automatic feed(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            pix_in = P'(first + i);
            pix_valid = 1;
            tick();
        end
        pix_valid = 0;
    endtask
    task automatic scan(input int n);
        win_ready = 1;
        for (int i = 0; i < n; i++) tick();
        win_ready = 0;
    endtask
    initial begin
        tick();
        tick();
        rst = 0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wv", 64'(win_valid), 64'd0);
        chk("rst_pr", 64'(pix_ready), 64'd0);
        chk("rst_sel", 64'(row_sel), 64'b001);
        chk("rst_col", 64'(col_cnt), 64'd0);
        chk("rst_bufs", 64'(r0 | r1 | r2), 64'd0);
        start = 1;
        tick();
        start = 0;
        chk("clear_busy", 64'(busy), 64'd1);
        chk("clear_pr", 64'(pix_ready), 64'd0);
        tick();
        chk("fill_pr", 64'(pix_ready), 64'd1);
        hs_cnt = 0;
        done_cnt = 0;
        for (int i = 1; i <= 8; i++) begin
            pix_in = P'(i);
            pix_valid = 1;
            tick();
            if (i == 7) chk("no_scan_yet", 64'(win_valid), 64'd0);
            if (i < 8) begin
                pix_valid = 0;
                pix_in = P'(100 + i);
                tick();
            end
        end
        pix_valid = 0;
        chk("scan_lat", 64'(win_valid), 64'd1);
        chk("r0_top_zero", 64'(r0), 64'd0);
        chk("r1_mid", 64'(r1), 64'(pk(1)));
        chk("r2_bot", 64'(r2), 64'(pk(5)));
        chk("scan_sel", 64'(row_sel), 64'b001);
        chk("scan_col0", 64'(col_cnt), 64'd0);
        scan(2);
        start = 1;
        pix_valid = 1;
        pix_in = P'(999);
        for (int i = 0; i < 5; i++) tick();
        start = 0;
        pix_valid = 0;
        chk("stall_col", 64'(col_cnt), 64'd2);
        chk("stall_sel", 64'(row_sel), 64'b001);
        chk("stall_wv", 64'(win_valid), 64'd1);
        chk("stall_r1", 64'(r1), 64'(pk(1)));
        chk("stall_r2", 64'(r2), 64'(pk(5)));
        chk("stall_r0", 64'(r0), 64'd0);
        scan(1);
        chk("resume_col", 64'(col_cnt), 64'd3);
        scan(1);
        chk("row1_sel", 64'(row_sel), 64'b010);
        chk("row1_col", 64'(col_cnt), 64'd0);
        chk("row1_fill", 64'(pix_ready), 64'd1);
        feed(9, 4);
        chk("row1_scan", 64'(win_valid), 64'd1);
        chk("row1_bot", 64'(r0), 64'(pk(9)));
        scan(4);
        chk("flush_wv", 64'(win_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd1);
        tick();
        chk("row2_sel", 64'(row_sel), 64'b100);
        chk("row2_bot_zero", 64'(r1), 64'd0);
        chk("row2_top", 64'(r2), 64'(pk(5)));
        chk("row2_mid", 64'(r0), 64'(pk(9)));
        chk("row2_wv", 64'(win_valid), 64'd1);
        scan(4);
        chk("done_pulse", 64'(done), 64'd1);
        tick();
        chk("done_low", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("hs_total", 64'(hs_cnt), 64'd12);
        chk("done_once", 64'(done_cnt), 64'd1);
        done_cnt = 0;
        do_start();
        feed(1, 8);
        scan(4);
        feed(9, 4);
        scan(1);
        rst = 1;
        tick();
        rst = 0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_wv", 64'(win_valid), 64'd0);
        chk("mrst_bufs", 64'(r0 | r1 | r2), 64'd0);
        chk("mrst_sel", 64'(row_sel), 64'b001);
        chk("mrst_col", 64'(col_cnt), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("mrst_nodone", 64'(done_cnt), 64'd0);
        do_start();
        feed(21, 8);
        chk("fresh_wv", 64'(win_valid), 64'd1);
        chk("fresh_r0", 64'(r0), 64'd0);
        chk("fresh_r1", 64'(r1), 64'(pk(21)));
        chk("fresh_r2", 64'(r2), 64'(pk(25)));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
